// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder feeding an in-order FIFO that drains to an IMEM write port.
// Optional immediate range/alignment checking is built when IMM_CHECK_EN is defined.
module instr_encoder #(
    parameter int                 DEPTH     = 4,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [2:0]                 fmt_i,
    input  logic [6:0]                 op_i,
    input  logic [4:0]                 rd_addr_i,
    input  logic [4:0]                 rs1_addr_i,
    input  logic [4:0]                 rs2_addr_i,
    input  logic [2:0]                 funct3_i,
    input  logic [6:0]                 funct7_i,
    input  logic [31:0]                imm_i,
    output logic                       wr_valid_o,
    input  logic                       wr_ready_i,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [31:0]                wr_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
        FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
    } fmt_e;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr, rptr_nxt;
    logic [CW-1:0] cnt_rem, cnt_nxt;
    logic [31:0]   word, head_nxt;
    logic          push, pop, bad;

    always_comb begin
        word = NOP;
        case (fmt_i)
            FMT_R: word = {funct7_i, rs2_addr_i, rs1_addr_i, funct3_i, rd_addr_i, op_i};
            FMT_I: word = {imm_i[11:0], rs1_addr_i, funct3_i, rd_addr_i, op_i};
            FMT_S: word = {imm_i[11:5], rs2_addr_i, rs1_addr_i, funct3_i, imm_i[4:0], op_i};
            FMT_B: word = {imm_i[12], imm_i[10:5], rs2_addr_i, rs1_addr_i, funct3_i,
                           imm_i[4:1], imm_i[11], op_i};
            FMT_U: word = {imm_i[31:12], rd_addr_i, op_i};
            FMT_J: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_addr_i, op_i};
            default: word = NOP;
        endcase
    end

`ifdef IMM_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm_i);

    always_comb begin
        bad = 1'b0;
        case (fmt_i)
            FMT_R:        bad = 1'b0;
            FMT_I, FMT_S: bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_i[0];
            FMT_U:        bad = (imm_i[11:0] != 12'd0);
            FMT_J:        bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm_i[0];
            default:      bad = 1'b1;
        endcase
    end
`else
    assign bad = 1'b0;
`endif

    assign req_ready_o = (count_o != FULL);
    assign push        = req_valid_i & req_ready_o & ~flush_i;
    assign pop         = wr_valid_o & wr_ready_i & ~flush_i;

    // Next head: the entry behind the popped one, or the incoming word if the FIFO runs dry.
    always_comb begin
        rptr_nxt = pop ? rptr + PW'(1) : rptr;
        cnt_rem  = count_o - CW'(pop);
        cnt_nxt  = cnt_rem + CW'(push);
        head_nxt = (cnt_rem == '0) ? word : mem[rptr_nxt];
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= word;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr       <= '0;
            rptr       <= '0;
            count_o    <= '0;
            wr_valid_o <= 1'b0;
            wr_data_o  <= '0;
            wr_addr_o  <= BASE_ADDR;
            err_o      <= 1'b0;
        end else if (flush_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count_o    <= '0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= BASE_ADDR;
            err_o      <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            rptr       <= rptr_nxt;
            count_o    <= cnt_nxt;
            wr_valid_o <= (cnt_nxt != '0);
            if (cnt_nxt != '0) wr_data_o <= head_nxt;
            if (pop) wr_addr_o <= wr_addr_o + ADDR_W'(4);
            if (push & bad) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO fill/stall/drain, flush, reset and error flag.
module tb_instr_encoder;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  fmt_i = '0;
    logic [6:0]  op_i = '0;
    logic [4:0]  rd_addr_i = '0, rs1_addr_i = '0, rs2_addr_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b0;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [2:0]  count_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .fmt_i(fmt_i), .op_i(op_i), .rd_addr_i(rd_addr_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .count_o(count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        fmt_i = f; op_i = op; rd_addr_i = rd; rs1_addr_i = rs1; rs2_addr_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    task automatic push_one(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
        set_req(f, op, rd, rs1, rs2, f3, f7, imm);
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    logic [31:0] exp_w;
    logic        exp_err;

    initial begin
`ifdef IMM_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        #12;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(wr_valid_o), 32'd0);
        chk("rst_data", wr_data_o, 32'h0);
        chk("rst_addr", wr_addr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready_o), 32'd1);

        // 1: R add x3,x1,x2 with memory ready
        wr_ready_i = 1'b1;
        push_one(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("r_valid", 32'(wr_valid_o), 32'd1);
        chk("r_data", wr_data_o, 32'h002081B3);
        chk("r_addr", wr_addr_o, 32'h0);
        tick();
        chk("r_empty", 32'(wr_valid_o), 32'd0);
        chk("r_addr_inc", wr_addr_o, 32'h4);
        chk("r_hold", wr_data_o, 32'h002081B3);

        // 2: I then S, drained in order
        do_flush();
        chk("fl_addr", wr_addr_o, 32'h0);
        wr_ready_i = 1'b0;
        push_one(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        push_one(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        chk("is_count", 32'(count_o), 32'd2);
        wr_ready_i = 1'b1;
        chk("i_data", wr_data_o, 32'hFFF00093);
        chk("i_addr", wr_addr_o, 32'h0);
        tick();
        chk("s_data", wr_data_o, 32'h0020A423);
        chk("s_addr", wr_addr_o, 32'h4);
        tick();
        chk("is_empty", 32'(wr_valid_o), 32'd0);

        // 3: B and J
        do_flush();
        wr_ready_i = 1'b0;
        push_one(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        push_one(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        chk("b_data", wr_data_o, 32'hFE208EE3);
        wr_ready_i = 1'b1;
        tick();
        chk("j_data", wr_data_o, 32'h008000EF);
        chk("j_addr", wr_addr_o, 32'h4);
        tick();

        // 4: fill to full with stall, fifth request refused, then drain
        do_flush();
        wr_ready_i = 1'b0;
        req_valid_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
            tick();
            chk("fill_count", 32'(count_o), (k < 4) ? 32'(k) : 32'd4);
        end
        req_valid_i = 1'b0;
        chk("full_ready", 32'(req_ready_o), 32'd0);
        chk("stall_data", wr_data_o, (32'd1 << 20) | 32'h93);
        tick();
        chk("stall_data2", wr_data_o, (32'd1 << 20) | 32'h93);
        chk("stall_addr", wr_addr_o, 32'h0);
        wr_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", 32'(wr_valid_o), 32'd1);
            chk("drain_data", wr_data_o, (32'(k) << 20) | 32'h93);
            chk("drain_addr", wr_addr_o, 32'((k - 1) * 4));
            tick();
        end
        chk("drain_empty", 32'(wr_valid_o), 32'd0);
        chk("drain_count", 32'(count_o), 32'd0);

        // simultaneous push and pop keeps count and order
        wr_ready_i = 1'b0;
        push_one(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        wr_ready_i = 1'b1;
        push_one(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        chk("pp_count", 32'(count_o), 32'd1);
        chk("pp_data", wr_data_o, (32'd9 << 20) | 32'h113);
        chk("pp_addr", wr_addr_o, 32'h14);
        tick();

        // 5: flush with a concurrent request drops everything
        do_flush();
        wr_ready_i = 1'b0;
        push_one(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        push_one(3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        set_req(3'd0, 7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        req_valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(wr_valid_o), 32'd0);
        chk("flush_addr", wr_addr_o, 32'h0);
        wr_ready_i = 1'b1;
        push_one(3'd0, 7'h33, 5'd6, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("post_flush_data", wr_data_o, 32'h00208333);
        chk("post_flush_addr", wr_addr_o, 32'h0);
        tick();

        // 6: out-of-range I immediate and illegal format
        do_flush();
        wr_ready_i = 1'b0;
        push_one(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("imm_trunc", wr_data_o, 32'h80000013);
        chk("imm_err", 32'(err_o), 32'(exp_err));
        tick();
        chk("imm_err_hold", 32'(err_o), 32'(exp_err));
        do_flush();
        chk("err_clr", 32'(err_o), 32'd0);
        push_one(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        chk("imm_min_ok", 32'(err_o), 32'd0);
        push_one(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        chk("illegal_err", 32'(err_o), 32'(exp_err));
        wr_ready_i = 1'b1;
        tick();
        chk("illegal_nop", wr_data_o, 32'h00000013);
        tick();

        // reset mid-drain discards contents and restarts the address
        wr_ready_i = 1'b0;
        push_one(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        push_one(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        wr_ready_i = 1'b1;
        tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_valid", 32'(wr_valid_o), 32'd0);
        chk("mid_rst_addr", wr_addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("after_rst_count", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
